fnd_scan_ctrl: RTL

//  Time-multiplexed scan controller for a multi-digit 7-segment (FND) array; upstream stage of the BCD-to-segment decoder.

---
 rtl/fnd_scan_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/fnd_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment digit array: walks one digit per slot,
// blanks at each slot start, and swaps in newly loaded frames only at frame boundaries.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
  input  logic [NUM_DIGITS-1:0]   DOTS_IN,
  input  logic                    LOAD,
  input  logic                    LZ_BLANK,
  output logic [3:0]              BCD,
  output logic                    DOT,
  output logic [NUM_DIGITS-1:0]   DIGIT_SEL_N,
  output logic                    FRAME_START
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]     pend_dot_q, pend_dot_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [4*NUM_DIGITS-1:0]   act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]     act_dot_q, act_dot_d;
  logic [3:0]                bcd_q, bcd_d;
  logic                      dot_q, dot_d;
  logic [NUM_DIGITS-1:0]     sel_n_q, sel_n_d;
  logic                      fs_q, fs_d;

  logic                      slot_end, frame_wrap, show, all_zero;
  logic [NUM_DIGITS-1:0]     lz_hide;
  logic [3:0]                cur_dig;

  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A LOAD on the wrap edge still lands in pending; active takes the previous pending.
    pend_dig_d = pend_dig_q;
    pend_dot_d = pend_dot_q;
    pend_vld_d = pend_vld_q;
    act_dig_d  = act_dig_q;
    act_dot_d  = act_dot_q;
    if (frame_wrap && pend_vld_q) begin
      act_dig_d  = pend_dig_q;
      act_dot_d  = pend_dot_q;
      pend_vld_d = 1'b0;
    end
    if (LOAD) begin
      pend_dig_d = DIGITS_IN;
      pend_dot_d = DOTS_IN;
      pend_vld_d = 1'b1;
    end

    // lz_hide[i]: digit i and every digit above it are zero; digit 0 is never hidden.
    all_zero = 1'b1;
    lz_hide  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (act_dig_q[4*i +: 4] == 4'h0);
      if (i > 0) lz_hide[i] = all_zero;
    end

    show    = (int'(cnt_q) >= BLANK_CYCLES);
    cur_dig = act_dig_q[4*idx_q +: 4];
    sel_n_d = '1;
    bcd_d   = 4'hF;
    dot_d   = 1'b0;
    if (show) begin
      sel_n_d[idx_q] = 1'b0;
      bcd_d          = (LZ_BLANK && lz_hide[idx_q]) ? 4'hF : cur_dig;
      dot_d          = act_dot_q[idx_q];
    end
    fs_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dot_q <= '0;
      pend_vld_q <= 1'b0;
      act_dig_q  <= '0;
      act_dot_q  <= '0;
      bcd_q      <= 4'hF;
      dot_q      <= 1'b0;
      sel_n_q    <= '1;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dot_q <= pend_dot_d;
      pend_vld_q <= pend_vld_d;
      act_dig_q  <= act_dig_d;
      act_dot_q  <= act_dot_d;
      bcd_q      <= bcd_d;
      dot_q      <= dot_d;
      sel_n_q    <= sel_n_d;
      fs_q       <= fs_d;
    end
  end

  assign BCD         = bcd_q;
  assign DOT         = dot_q;
  assign DIGIT_SEL_N = sel_n_q;
  assign FRAME_START = fs_q;

endmodule
